// File: rtl/addition.sv
// Sequential IEEE-754 single-precision adder. The smaller operand is aligned one bit per
// cycle, the mantissas are combined in one cycle, and the sum is normalized one bit per
// cycle. Rounding is truncation only. Shares its interface with the subtraction unit.
module addition #(
    parameter int unsigned MAX_ALIGN = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  flag_a,
    input  logic [4:0]  flag_b,
    input  logic        available,
    output logic [31:0] out,
    output logic        done,
    output logic        status
);

    localparam int unsigned DW = $clog2(MAX_ALIGN + 1);

    typedef enum logic [2:0] {
        StIdle, StStart, StException, StAlign, StAdd, StNorm, StDone
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     out_q, out_d;
    logic [24:0]     big_q, big_d;
    logic [24:0]     small_q, small_d;
    logic [24:0]     sum_q, sum_d;
    logic [7:0]      exp_q, exp_d;
    logic [DW-1:0]   d_q, d_d;
    logic            sign_q, sign_d;
    logic            sub_q, sub_d;
    logic            far_q, far_d;

    // Operand ordering and alignment distance, evaluated while in START.
    logic          a_ge;
    logic [31:0]   big_op, small_op;
    logic [7:0]    exp_diff;
    logic          far;
    logic [DW-1:0] d_load;

    // Special-case result, evaluated while in EXCEPTION.
    logic        a_zero, b_zero;
    logic [31:0] exc_result;

    // Reserved class bit is deliberately ignored.
    logic unused_flags;
    assign unused_flags = flag_a[4] ^ flag_b[4];

    // Magnitude compare on {exp, frac} and clamped exponent difference.
    always_comb begin
        a_ge     = a[30:0] >= b[30:0];
        big_op   = a_ge ? a : b;
        small_op = a_ge ? b : a;
        exp_diff = big_op[30:23] - small_op[30:23];
        far      = 32'(exp_diff) >= MAX_ALIGN;
        d_load   = far ? DW'(MAX_ALIGN) : exp_diff[DW-1:0];
    end

    // Special-operand resolution in priority order; subnormals count as zero.
    always_comb begin
        a_zero = flag_a[0] | flag_a[3];
        b_zero = flag_b[0] | flag_b[3];
        if (flag_a[2] || flag_b[2]) begin
            exc_result = 32'h7FC0_0000;
        end else if (flag_a[1] && flag_b[1] && (a[31] ^ b[31])) begin
            exc_result = 32'h7FC0_0000;
        end else if (flag_a[1]) begin
            exc_result = a;
        end else if (flag_b[1]) begin
            exc_result = b;
        end else if (a_zero && b_zero) begin
            exc_result = {a[31] & b[31], 31'b0};
        end else if (a_zero) begin
            exc_result = b;
        end else begin
            exc_result = a;
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        big_d   = big_q;
        small_d = small_q;
        sum_d   = sum_q;
        exp_d   = exp_q;
        d_d     = d_q;
        sign_d  = sign_q;
        sub_d   = sub_q;
        far_d   = far_q;

        unique case (state_q)
            StIdle: begin
                if (available) state_d = StStart;
            end
            StStart: begin
                if ((|flag_a[3:0]) || (|flag_b[3:0])) begin
                    state_d = StException;
                end else begin
                    big_d   = {2'b01, big_op[22:0]};
                    small_d = {2'b01, small_op[22:0]};
                    exp_d   = big_op[30:23];
                    sign_d  = big_op[31];
                    sub_d   = a[31] ^ b[31];
                    far_d   = far;
                    d_d     = d_load;
                    state_d = (d_load == '0) ? StAdd : StAlign;
                end
            end
            StException: begin
                out_d   = exc_result;
                state_d = StDone;
            end
            StAlign: begin
                small_d = small_q >> 1;
                d_d     = d_q - DW'(1);
                if (d_q == DW'(1)) begin
                    if (far_q) small_d = '0;
                    state_d = StAdd;
                end
            end
            StAdd: begin
                // big >= small by construction, so the difference never wraps.
                sum_d   = sub_q ? (big_q - small_q) : (big_q + small_q);
                state_d = StNorm;
            end
            StNorm: begin
                if (sum_q == '0) begin
                    out_d   = 32'h0000_0000;
                    state_d = StDone;
                end else if (sum_q[24]) begin
                    if (exp_q == 8'd254) begin
                        out_d   = {sign_q, 8'hFF, 23'b0};
                        state_d = StDone;
                    end else begin
                        sum_d = sum_q >> 1;
                        exp_d = exp_q + 8'd1;
                    end
                end else if (sum_q[23]) begin
                    out_d   = {sign_q, exp_q, sum_q[22:0]};
                    state_d = StDone;
                end else if (exp_q <= 8'd1) begin
                    // Underflow flushes to a signed zero.
                    out_d   = {sign_q, 31'b0};
                    state_d = StDone;
                end else begin
                    sum_d = sum_q << 1;
                    exp_d = exp_q - 8'd1;
                end
            end
            StDone: begin
                state_d = StDone;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Dropping the request aborts from any state without touching the result.
        if (!available) begin
            state_d = StIdle;
            out_d   = out_q;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            out_q   <= '0;
            big_q   <= '0;
            small_q <= '0;
            sum_q   <= '0;
            exp_q   <= '0;
            d_q     <= '0;
            sign_q  <= 1'b0;
            sub_q   <= 1'b0;
            far_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            big_q   <= big_d;
            small_q <= small_d;
            sum_q   <= sum_d;
            exp_q   <= exp_d;
            d_q     <= d_d;
            sign_q  <= sign_d;
            sub_q   <= sub_d;
            far_q   <= far_d;
        end
    end

    assign out    = out_q;
    assign done   = (state_q == StDone);
    assign status = (state_q == StStart) || (state_q == StException) ||
                    (state_q == StAlign) || (state_q == StAdd) || (state_q == StNorm);

endmodule

// File: tb/tb_addition.sv
// Scoreboard bench for the sequential single-precision adder.
module tb_addition;

    logic        clk;
    logic        rst;
    logic [31:0] a, b;
    logic [4:0]  flag_a, flag_b;
    logic        available;
    logic [31:0] out;
    logic        done;
    logic        status;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp;
    int   n_bad;

    addition #(
        .MAX_ALIGN(25)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .flag_a   (flag_a),
        .flag_b   (flag_b),
        .available(available),
        .out      (out),
        .done     (done),
        .status   (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Drive one operation, push its expectation, wait for done and compare.
    // A negative expected latency skips the latency comparison.
    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                          input logic [4:0] fa, input logic [4:0] fb,
                          input logic [31:0] want, input int want_lat);
        int   lat;
        logic st_ok;
        exp_t e;
        a         = ta;
        b         = tb;
        flag_a    = fa;
        flag_b    = fb;
        available = 1'b1;
        sb_q.push_back('{res: want, lat: want_lat});
        lat   = 0;
        st_ok = 1'b1;
        while (lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done) break;
            if (!status) st_ok = 1'b0;
        end
        e = sb_q.pop_front();
        check({tag, " out"}, out, e.res);
        if (e.lat >= 0) check({tag, " latency"}, lat, e.lat);
        check({tag, " status busy"}, {31'b0, st_ok}, 32'd1);
        check({tag, " done-status excl"}, {31'b0, status}, 32'd0);
        available = 1'b0;
        @(negedge clk);
        check({tag, " idle after drop"}, {30'b0, done, status}, 32'd0);
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        available = 1'b0;
        a         = '0;
        b         = '0;
        flag_a    = '0;
        flag_b    = '0;
        repeat (2) @(negedge clk);
        check("reset out", out, 32'h0);
        check("reset flags", {30'b0, done, status}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Normal path: latency 4 + d + n.
        run_op("1+1",        32'h3F80_0000, 32'h3F80_0000, 5'b0, 5'b0, 32'h4000_0000, 5);
        run_op("1.5+0.25",   32'h3FC0_0000, 32'h3E80_0000, 5'b0, 5'b0, 32'h3FE0_0000, 6);
        run_op("1-0.75",     32'h3F80_0000, 32'hBF40_0000, 5'b0, 5'b0, 32'h3E80_0000, 7);
        run_op("pi-pi",      32'h4049_0FDB, 32'hC049_0FDB, 5'b0, 5'b0, 32'h0000_0000, 4);
        run_op("max+max",    32'h7F7F_FFFF, 32'h7F7F_FFFF, 5'b0, 5'b0, 32'h7F80_0000, -1);
        // Exponent gap of 25 hits the alignment cap and drops the small operand.
        run_op("far gap",    32'h4C00_0000, 32'h3F80_0000, 5'b0, 5'b0, 32'h4C00_0000, 29);
        // Reserved class bit must not divert to the exception path.
        run_op("rsvd flag",  32'h3F80_0000, 32'h3F80_0000, 5'b10000, 5'b10000,
               32'h4000_0000, 5);
        run_op("swap order", 32'h3E80_0000, 32'hBFC0_0000, 5'b0, 5'b0, 32'hBFA0_0000, 6);

        // Exception path: latency 3.
        run_op("nan a",      32'h7FC0_0001, 32'h3F80_0000, 5'b00100, 5'b0, 32'h7FC0_0000, 3);
        run_op("inf-inf",    32'h7F80_0000, 32'hFF80_0000, 5'b00010, 5'b00010,
               32'h7FC0_0000, 3);
        run_op("-inf+1",     32'hFF80_0000, 32'h3F80_0000, 5'b00010, 5'b0, 32'hFF80_0000, 3);
        run_op("0+3",        32'h0000_0000, 32'h4040_0000, 5'b00001, 5'b0, 32'h4040_0000, 3);
        run_op("-0+-0",      32'h8000_0000, 32'h8000_0000, 5'b00001, 5'b00001,
               32'h8000_0000, 3);
        run_op("+0+-0",      32'h0000_0000, 32'h8000_0000, 5'b00001, 5'b00001,
               32'h0000_0000, 3);
        run_op("sub+2",      32'h4000_0000, 32'h0000_0001, 5'b0, 5'b01000, 32'h4000_0000, 3);
        run_op("1+1 again",  32'h3F80_0000, 32'h3F80_0000, 5'b0, 5'b0, 32'h4000_0000, 5);

        // Abort on the 5th ALIGN cycle (after edge 6).
        a         = 32'h4B00_0000;
        b         = 32'h3F80_0000;
        flag_a    = '0;
        flag_b    = '0;
        available = 1'b1;
        repeat (6) @(negedge clk);
        check("abort busy", {31'b0, status}, 32'd1);
        available = 1'b0;
        @(negedge clk);
        check("abort flags", {30'b0, done, status}, 32'd0);
        check("abort out kept", out, 32'h4000_0000);
        @(negedge clk);
        check("abort stays idle", {30'b0, done, status}, 32'd0);

        // Synchronous reset mid-ALIGN.
        available = 1'b1;
        repeat (4) @(negedge clk);
        check("pre-reset busy", {31'b0, status}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid reset out", out, 32'h0);
        check("mid reset flags", {30'b0, done, status}, 32'd0);
        rst       = 1'b0;
        available = 1'b0;
        @(negedge clk);

        if (sb_q.size() != 0) check("scoreboard drained", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/addition.md
Name: addition

Overview:
- Sequential IEEE-754 single-precision floating-point adder. It is the additive counterpart of the team's subtraction unit and uses the same operand, flag and handshake interface, so both units can sit side by side behind the same operand classifier.
- The FSM aligns the smaller operand one bit per cycle, adds or subtracts the mantissas according to the signs, then normalizes one bit per cycle.
- Results are registered. `done` and `status` follow the same level semantics as the sibling unit.

Parameters:
- MAX_ALIGN, 25, cap on alignment shift cycles. A larger exponent difference zeroes the small mantissa.

Ports:
- clk  input  1  single clock, all logic on posedge
- rst  input  1  synchronous, active-high reset
- a  input  32  operand A, IEEE-754 single
- b  input  32  operand B, IEEE-754 single
- flag_a  input  5  class of A: [0] zero, [1] infinity, [2] NaN, [3] subnormal, [4] reserved (ignored)
- flag_b  input  5  class of B, same encoding as flag_a
- available  input  1  level request; operands and flags must stay stable while it is high
- out  output  32  registered result
- done  output  1  high while the FSM is in DONE
- status  output  1  high in START, EXCEPTION, ALIGN, ADD, NORM

Behaviour:
- Reset and idle:
  - rst=1 at a posedge: state=IDLE, out=0, internal registers cleared. rst has priority over everything else.
  - available=0 at a posedge (rst=0): state=IDLE at any point, including mid-operation. out keeps its last value.
- States: IDLE, START, EXCEPTION, ALIGN, ADD, NORM, DONE.
- IDLE -> START when available=1.
- START:
  - If any of flag_a[3:0] or flag_b[3:0] is set -> EXCEPTION.
  - Otherwise, order operands by magnitude: compare exponent first, then mantissa. The larger is "big", the other "small".
  - Load 25-bit mantissas {0, 1, frac}. Load counter d = min(exp_big - exp_small, MAX_ALIGN).
  - d>0 -> ALIGN; d=0 -> ADD.
- ALIGN:
  - Each cycle: small mantissa >>1 and d-1.
  - Leave for ADD on the cycle d goes 1->0. ALIGN therefore occupies exactly d cycles.
  - If exp difference >= MAX_ALIGN, the small mantissa is set to 0 once alignment completes.
  - Shifted-out bits are discarded: no guard, round or sticky bits, truncation only.
- ADD (one cycle):
  - Signs equal: sum = big + small.
  - Signs differ: sum = big - small, never negative.
  - Result sign = sign of big. Result exponent = exp_big. Next state NORM.
- NORM, one action per cycle:
  - sum=0 -> result +0 (0x00000000) -> DONE.
  - sum[24]=1 -> sum>>1, exp+1. If the new exp = 255, result = signed infinity -> DONE.
  - sum[24:23]=01 -> pack {sign, exp, sum[22:0]} -> DONE.
  - sum[24:23]=00 -> sum<<1, exp-1. If exp reaches 0, result = signed zero (flush) -> DONE.
- EXCEPTION (one cycle, then DONE). Priority order:
  - Either operand NaN -> 0x7FC00000.
  - Both infinite with opposite signs -> 0x7FC00000.
  - Any infinite -> that infinity.
  - Zero or subnormal operands are treated as zero: both zero -> +0, except -0 when both signs are 1; one zero -> the other operand unchanged.
- out is written only on the transition into DONE.
- DONE holds while available=1. The next operation requires available to drop, which returns the FSM to IDLE, then rise again.
- Latency, counting posedges from the first edge that samples available=1 until done=1:
  - Normal path: 4 + d + n, where n = number of NORM shifts.
  - Exception path: 3.

Test Plan:
- 0x3F800000 + 0x3F800000 (1+1): d=0, n=1 -> out=0x40000000, done after 5 edges, status=1 on edges 1-4.
- 0x3FC00000 + 0x3E800000 (1.5+0.25): d=2, n=0 -> out=0x3FE00000, done after 6 edges.
- 0x3F800000 + 0xBF400000 (1-0.75): d=1, n=2 -> out=0x3E800000, done after 7 edges.
- 0x40490FDB + 0xC0490FDB -> out=0x00000000 after 4 edges. 0x7F7FFFFF + 0x7F7FFFFF -> out=0x7F800000.
- Exception path, each -> done after 3 edges:
  - flag_a=00100 -> out=0x7FC00000.
  - 0x7F800000 + 0xFF800000 with both flags=00010 -> out=0x7FC00000.
  - a=0, flag_a=00001, b=0x40400000 -> out=0x40400000.
- Abort and reset mid-operation:
  - 0x4B000000 + 0x3F800000 (d=23): drop available on the 5th ALIGN cycle -> IDLE next edge, status=0, done=0, out keeps its prior value.
  - Same operands again, assert rst mid-ALIGN -> out=0, IDLE.
